// File: rtl/load_register_pkg.sv
// Shared datapath register constants: default width and reset value used by
// every architectural register instance.
package load_register_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned MAX_WIDTH  = 64;

  localparam logic [DATA_WIDTH-1:0] DEFAULT_RESET_VALUE = DATA_WIDTH'(0);

endpackage : load_register_pkg

// File: rtl/load_register.sv
// Parallel-load storage register with async active-low reset, synchronous
// clear (priority over load) and a "loaded since reset/clear" flag.
module load_register
  import load_register_pkg::*;
#(
  parameter int unsigned     WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid
);

  // Clear beats load; d_in is only sampled when load is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_out   <= RESET_VALUE;
      q_valid <= 1'b0;
    end else if (clear) begin
      q_out   <= RESET_VALUE;
      q_valid <= 1'b0;
    end else if (load) begin
      q_out   <= d_in;
      q_valid <= 1'b1;
    end
  end

endmodule : load_register

// File: tb/tb_load_register.sv
// Scoreboard bench for load_register: an 8-bit default instance and a 16-bit
// instance with a non-zero reset value share the control inputs.
module tb_load_register;

  localparam logic [7:0]  RV8  = 8'h00;
  localparam logic [15:0] RV16 = 16'hBEEF;

  typedef struct packed {
    logic [7:0]  q8;
    logic        v8;
    logic [15:0] q16;
    logic        v16;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        load;
  logic        clear;
  logic [7:0]  d_in8;
  logic [15:0] d_in16;
  logic [7:0]  q_out8;
  logic        q_valid8;
  logic [15:0] q_out16;
  logic        q_valid16;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  exp_t        sb[$];
  logic [7:0]  m_q8;
  logic        m_v8;
  logic [15:0] m_q16;
  logic        m_v16;

  load_register #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .clear   (clear),
    .d_in    (d_in8),
    .q_out   (q_out8),
    .q_valid (q_valid8)
  );

  load_register #(.WIDTH(16), .RESET_VALUE(RV16)) u_dut16 (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .clear   (clear),
    .d_in    (d_in16),
    .q_out   (q_out16),
    .q_valid (q_valid16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.q8  = m_q8;
    e.v8  = m_v8;
    e.q16 = m_q16;
    e.v16 = m_v16;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_q8"},  64'(q_out8),    64'(e.q8));
      check({tag, "_v8"},  64'(q_valid8),  64'(e.v8));
      check({tag, "_q16"}, 64'(q_out16),   64'(e.q16));
      check({tag, "_v16"}, 64'(q_valid16), 64'(e.v16));
    end
  endtask

  task automatic model_reset();
    m_q8  = RV8;
    m_v8  = 1'b0;
    m_q16 = RV16;
    m_v16 = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the post-edge state, compare after the edge.
  task automatic step(input logic ld, input logic clr, input logic [7:0] d8,
                      input logic [15:0] d16, input string tag);
    load   = ld;
    clear  = clr;
    d_in8  = d8;
    d_in16 = d16;
    if (!reset || clr) begin
      model_reset();
    end else if (ld) begin
      m_q8  = d8;
      m_v8  = 1'b1;
      m_q16 = d16;
      m_v16 = 1'b1;
    end
    push_model();
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Expect the current model state right now, between clock edges.
  task automatic expect_now(input string tag);
    push_model();
    #1;
    pop_check(tag);
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b1;
    clear  = 1'b0;
    d_in8  = 8'hFF;
    d_in16 = 16'hFFFF;
    m_q8   = 8'h00;
    m_v8   = 1'b0;
    m_q16  = 16'h0000;
    m_v16  = 1'b0;

    // Power-up reset takes effect before any clock edge
    #1 reset = 1'b0;
    model_reset();
    expect_now("por_async");
    step(1'b1, 1'b0, 8'hFF, 16'hFFFF, "por_hold0");
    step(1'b1, 1'b0, 8'hFF, 16'hFFFF, "por_hold1");

    reset = 1'b1;
    step(1'b1, 1'b0, 8'hAA, 16'h1234, "load_aa");
    step(1'b0, 1'b0, 8'hAA, 16'h1234, "hold_aa0");
    step(1'b0, 1'b0, 8'hAA, 16'h1234, "hold_aa1");

    step(1'b0, 1'b0, 8'hCC, 16'h5555, "idle_d0");
    step(1'b0, 1'b0, 8'h33, 16'hAAAA, "idle_d1");
    step(1'b0, 1'b0, 8'hCC, 16'h5555, "idle_d2");
    step(1'b1, 1'b0, 8'hCC, 16'h5555, "load_cc");

    // Mid-cycle d_in change with load high must not reach q_out before an edge
    load  = 1'b1;
    d_in8 = 8'h99;
    d_in16 = 16'h9999;
    expect_now("not_transparent");

    // Async reset mid-cycle, coinciding with a load request
    #2;
    reset  = 1'b0;
    load   = 1'b1;
    d_in8  = 8'h77;
    d_in16 = 16'h7777;
    model_reset();
    expect_now("async_mid");
    step(1'b1, 1'b0, 8'h77, 16'h7777, "async_hold");
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h77, 16'h7777, "post_release");

    step(1'b1, 1'b0, 8'h00, 16'hBEEF, "load_rv");
    step(1'b1, 1'b0, 8'h5A, 16'h0F0F, "load_5a");
    step(1'b1, 1'b1, 8'h3C, 16'h3C3C, "clr_vs_load");
    step(1'b1, 1'b0, 8'h3C, 16'h3C3C, "load_3c");
    step(1'b0, 1'b1, 8'hE1, 16'hE1E1, "clr_only");
    step(1'b0, 1'b0, 8'hE1, 16'hE1E1, "hold_clr");

    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           8'($urandom), 16'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_load_register

// File: doc/load_register.md
Name: load_register

Overview:
- Parameterised parallel-load storage register with asynchronous active-low reset.
- Generic state element of the single-cycle processor datapath (accumulator/operand/instruction holding registers).
- Captures d_in on a rising clock edge when load is high; otherwise holds its value.
- Adds a synchronous clear and a "loaded since reset" status flag.

Parameters:
- WIDTH, 8, data width in bits (legal range 1..64).
- RESET_VALUE, 0 (WIDTH bits), value forced onto q_out by reset and by clear.

Ports:
- clk  input  1  system clock; all synchronous activity on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  synchronous load enable; 1 = capture d_in on this rising edge.
- clear  input  1  synchronous clear, active-high; tie to 0 if unused.
- d_in  input  WIDTH  parallel data to store.
- q_out  output  WIDTH  stored value, driven directly from the flops with no output logic.
- q_valid  output  1  1 once the register has been loaded since the last reset or clear.

Behaviour:
- Reset:
  - reset low forces q_out = RESET_VALUE and q_valid = 0 immediately, with no clock edge needed.
  - Both stay forced for as long as reset is low; clk, load, clear and d_in are ignored.
- Reset release:
  - The first possible update is the first rising clk edge at which reset is high.
  - Release must be synchronised externally; this block has no internal synchroniser.
- Priority at a rising edge with reset high, highest first:
  1. clear = 1: q_out <= RESET_VALUE, q_valid <= 0. This wins over load when both are high.
  2. load = 1: q_out <= d_in, q_valid <= 1.
  3. Otherwise: hold q_out and q_valid.
- Latency: one clock. d_in sampled at edge N appears on q_out just after edge N. Load is not transparent: d_in changes between edges never reach q_out.
- Changes on d_in while load = 0 have no effect on q_out.
- Loading a value equal to RESET_VALUE (including 0) still sets q_valid = 1.
- Reset asserted mid-cycle, including at the same instant as load = 1: reset wins and the load is lost.
- No handshake, no arithmetic, no wrap-around; pure storage.
- No X propagation from an idle d_in: q_out only samples d_in when load = 1.

Decomposition:
- Shared package holds the default datapath width constant (DATA_WIDTH = 8) and the default reset-value constant, so every datapath register instance shares them.
- No sub-module: a single always block for the flops plus the priority mux.
- The processor instantiates this block once per architectural register.

Test Plan:
1. Power-up reset: drive reset = 0 for 10 ns with d_in = 8'hFF and load = 1 -> q_out = 8'h00 and q_valid = 0 without waiting for a clock edge, and they stay there throughout.
2. Load: release reset, then load = 1 with d_in = 8'hAA for one edge, then load = 0 -> q_out = 8'hAA one edge later and q_valid = 1. q_out holds 8'hAA on later edges.
3. Hold: with load = 0, change d_in to 8'hCC across several edges -> q_out stays 8'hAA. Then pulse load for one edge -> q_out = 8'hCC.
4. Async reset mid-cycle: with q_out = 8'hCC, drop reset between clock edges -> q_out = 8'h00 and q_valid = 0 immediately. Both remain at reset values through reset release until the next load.
5. Clear priority: with q_out = 8'h5A, assert clear = 1 and load = 1 with d_in = 8'h3C on the same edge -> q_out = 8'h00 and q_valid = 0. Repeat with clear = 0 -> q_out = 8'h3C.
6. Parameter check: instantiate WIDTH = 16 with RESET_VALUE = 16'hBEEF -> reset gives 16'hBEEF, and loading 16'h1234 gives 16'h1234.
